// File: rtl/stream_mux_nx1.sv
// rtl/stream_mux_nx1.sv - N-channel stream multiplexer with packet-locked arbitration and registered output
//
// Selects one of N_CH input streams and forwards its beats to a single
// registered output. A channel keeps the grant from its first beat until
// its beat with in_last=1 has been accepted.
//
// Parameters:
//   N_CH   number of input channels (2..16)
//   DATA_W data width per channel
//   MODE   0 = round-robin, 1 = fixed priority (lowest index), 2 = manual via sel
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel beat valid
//   in_data    packed channel data, channel i at [i*DATA_W +: DATA_W]
//   in_last    per-channel end-of-packet flag
//   in_ready   per-channel accept (combinational)
//   sel        manual channel select, only used when MODE=2
//   out_valid  output register holds a beat
//   out_data   registered data
//   out_last   registered end-of-packet flag
//   out_ch     source channel of the current output beat
//   out_ready  downstream accept
module stream_mux_nx1 #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [SEL_W-1:0]       out_ch,
    input  logic                   out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_grant;
    logic [SEL_W-1:0]   w_grant_nxt;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [SEL_W-1:0]   w_rr_nxt;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [SEL_W-1:0]   r_out_ch;

    logic               w_slot_free;
    logic [SEL_W-1:0]   w_cand;
    logic               w_cand_ok;
    logic [SEL_W-1:0]   w_idx;
    int                 w_idx_int;
    logic [SEL_W-1:0]   w_src;
    logic               w_src_ok;
    logic               w_xfer;
    logic [DATA_W-1:0]  w_src_data;
    logic               w_src_last;

    // The output register can take a new beat when it is empty or is being
    // drained this cycle, which keeps full throughput without a bubble.
    assign w_slot_free = !r_out_valid || out_ready;

    // Candidate selection for the IDLE state.
    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        w_idx     = '0;
        w_idx_int = 0;
        if (MODE == 2) begin
            if ((int'(sel) < N_CH) && in_valid[sel]) begin
                w_cand    = sel;
                w_cand_ok = 1'b1;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                // Round-robin searches upward from rr_ptr with wrap; fixed
                // priority searches upward from channel 0.
                w_idx_int = (MODE == 1) ? k : int'(r_rr_ptr) + k;
                if (w_idx_int >= N_CH) begin
                    w_idx_int = w_idx_int - N_CH;
                end
                w_idx = w_idx_int[SEL_W-1:0];
                if (!w_cand_ok && in_valid[w_idx]) begin
                    w_cand    = w_idx;
                    w_cand_ok = 1'b1;
                end
            end
        end
    end

    // While locked only the granted channel is eligible; sel and other
    // requests are ignored until the packet's last beat.
    assign w_src      = (r_state == LOCKED) ? r_grant : w_cand;
    assign w_src_ok   = (r_state == LOCKED) ? 1'b1 : w_cand_ok;
    assign w_src_data = in_data[int'(w_src)*DATA_W +: DATA_W];
    assign w_src_last = in_last[w_src];
    assign w_xfer     = rst_n && w_src_ok && w_slot_free && in_valid[w_src];

    // in_ready is gated by rst_n so it drops immediately on reset assertion.
    always_comb begin
        in_ready = '0;
        if (rst_n && w_src_ok && w_slot_free) begin
            in_ready[w_src] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        if (w_xfer) begin
            if (w_src_last) begin
                w_state_nxt = IDLE;
                w_rr_nxt    = (w_src == SEL_W'(N_CH - 1)) ? '0 : w_src + 1'b1;
            end else if (r_state == IDLE) begin
                w_state_nxt = LOCKED;
                w_grant_nxt = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_src_data;
            r_out_last  <= w_src_last;
            r_out_ch    <= w_src;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
- Parametrised N-channel, W-bit stream multiplexer with per-channel valid/ready/last handshake and a registered output stage.
- Selects one input channel by round-robin, fixed priority or external select.
- Holds the grant for a whole packet, from first beat to the beat with last=1.
- Sits between parallel producers and a single shared downstream consumer.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, data width per channel.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins), 2 = manual via sel.
- SEL_W, derived local = clog2(N_CH), channel index width; not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N_CH  per-channel beat valid.
- in_data  in  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel accept.
- sel  in  SEL_W  manual channel select; used only when MODE=2.
- out_valid  out  1  output register holds a beat.
- out_data  out  DATA_W  registered data.
- out_last  out  1  registered last flag.
- out_ch  out  SEL_W  source channel of the current output beat.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset: async assert forces out_valid=0, out_data=0, out_last=0, out_ch=0, state=IDLE, grant=0, rr_ptr=0.
  - in_ready is all-zero while rst_n=0.
  - A beat in flight at reset is discarded.
  - Deassertion is taken synchronously.
- Slot free: slot_free = !out_valid || out_ready. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Latency: an accepted beat appears on out_* on the next clock edge.
  - Back-to-back beats at full rate when out_ready stays high.
  - If out_ready=0 while out_valid=1, out_* hold stable and no input is accepted.
- IDLE state:
  - Arbiter picks cand from channels with in_valid=1.
  - MODE 0: first valid channel at or after rr_ptr, searching upward with wrap to 0.
  - MODE 1: lowest-index valid channel.
  - MODE 2: cand=sel, but only if in_valid[sel]=1; otherwise no candidate. sel >= N_CH means no candidate.
  - in_ready[cand]=slot_free; all other bits are 0.
  - On transfer with last=0: grant<=cand, go to LOCKED.
  - On transfer with last=1 (single-beat packet): stay in IDLE; rr_ptr <= cand+1 (mod N_CH).
  - No candidate: in_ready=0, no state change.
- LOCKED state:
  - Only in_ready[grant]=slot_free; other channels are stalled even if valid.
  - Changes on sel and higher-priority requests are ignored.
  - Transfer with last=1: go to IDLE; rr_ptr <= grant+1 (mod N_CH).
  - in_valid[grant]=0 mid-packet (bubble): stay LOCKED, no output beat is generated.
- rr_ptr changes only on packet completion. In MODE 1/2 it is tracked but has no effect.
- out_ch is loaded together with out_data on every accepted beat.
- in_ready may depend combinationally on in_valid, sel and out_ready. out_* have no combinational path from inputs.
- Simultaneous output accept and new input beat in the same cycle must not create a bubble. This is full-throughput behaviour.

Test Plan:
1. Reset mid-packet: lock ch2 with a 3-beat packet, assert rst_n=0 after beat 1 -> out_valid=0 and in_ready=0 immediately (asynchronously). After release, ch0 is granted first (rr_ptr=0).
2. Round-robin, MODE 0: all 4 channels continuously valid with single-beat packets, data = 8'hA0+ch, out_ready=1 -> out_ch sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0; one beat per clock after the first.
3. Packet lock: ch1 sends a 3-beat packet (11,12,13, last on 13) while ch0 is valid throughout -> outputs 11,12,13 from ch1 without interruption, then ch0. in_ready[0]=0 during the lock.
4. Backpressure: out_ready=0 for 5 cycles with out_valid=1 holding 8'h5A -> out_data stays 5A and all in_ready=0. out_ready=1 -> next beat follows on the very next edge.
5. Fixed priority, MODE 1: ch3 valid, then ch0 raised after the ch3 single-beat packet is accepted -> ch0 wins over ch3 on every subsequent arbitration.
6. Manual, MODE 2: sel=2 with only ch1 valid -> no transfer. sel=1 -> ch1 is accepted. sel changed to 3 mid-packet -> ignored until last.
